// File: rtl/pipe_cpu_pkg.sv
// Shared pipeline CPU definitions.
// Holds the divider state encoding and its decoder constants.
package pipe_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int XLEN = 32;

    localparam logic [5:0] FUNCT_DIVU = 6'd27;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/divu_seq_if.sv
// Start/done handshake bundle between the hazard unit and the divider.
// Carries operands in and registered results back.
interface divu_seq_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             kill;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;

    modport master (
        output start, kill, dataA, dataB,
        input  busy, done, quot, rem, div_zero
    );

    modport slave (
        input  start, kill, dataA, dataB,
        output busy, done, quot, rem, div_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration.
// The subtract adds the inverted divisor plus one, as the ALU does.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] s;
    logic [WIDTH:0] t;
    logic           unused_r_msb;

    // R stays below D, so its top bit never reaches the shifted value
    assign unused_r_msb = r_i[WIDTH];

    always_comb begin
        s = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
        t = s + {1'b1, ~d_i} + {{WIDTH{1'b0}}, 1'b1};
        if (!t[WIDTH]) begin
            r_o = t;
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = s;
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu_seq.sv
// Multi-cycle unsigned divider beside the EX-stage ALU.
// Holds the FSM, iteration counter and registered results.
module divu_seq
    import pipe_cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    divu_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d, r_step;
    logic [WIDTH-1:0] q_q, q_d, q_step;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             zero_div;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_step),
        .q_o (q_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        accept   = bus.start && !bus.kill &&
                   (state_q == IDLE || state_q == DONE);
        zero_div = (bus.dataB == '0);

        unique case (state_q)
            IDLE: state_d = IDLE;
            DONE: state_d = IDLE;
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    quot_d  = q_step;
                    rem_d   = r_step[WIDTH-1:0];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            d_d   = bus.dataB;
            q_d   = bus.dataA;
            r_d   = '0;
            cnt_d = CNT_INIT;
            dz_d  = 1'b0;
            if (zero_div) begin
                state_d = DONE;
                quot_d  = WIDTH'(DIV_ZERO_QUOT);
                rem_d   = bus.dataA;
                dz_d    = 1'b1;
                done_d  = 1'b1;
            end else begin
                state_d = CALC;
            end
        end

        // A flush leaves the previously reported results untouched
        if (bus.kill) begin
            state_d = IDLE;
            done_d  = 1'b0;
            quot_d  = quot_q;
            rem_d   = rem_q;
            dz_d    = dz_q;
        end

        busy_d = (state_d == CALC) || (accept && zero_div);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = dz_q;

endmodule

// File: doc/divu_seq.md
# divu_seq

Multi-cycle unsigned divider for the pipelined CPU. It sits beside the combinational ALU in EX and consumes the same operands (dataA dividend, dataB divisor). It computes the quotient and remainder by restoring shift-subtract, which is the subtract path run iteratively in reverse of multiply, and returns results to the hazard unit over a start/done handshake. The pipeline stalls on `busy`.

## Interface
- WIDTH, 32: operand and result width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a divide; sampled only when the unit is accepting (IDLE or DONE).
- kill, input, 1: pipeline flush; aborts any operation.
- dataA, input, WIDTH: dividend, captured on accepted start.
- dataB, input, WIDTH: divisor, captured on accepted start.
- busy, output, 1: high in CALC, and in the cycle after accepting a divide-by-zero.
- done, output, 1: one-cycle pulse when results become valid.
- quot, output, WIDTH: quotient; held until the next accepted start.
- rem, output, WIDTH: remainder; held until the next accepted start.
- div_zero, output, 1: set with done when the divisor was 0; held with the results.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: results valid, lasts one cycle.
- Accepted start (state IDLE or DONE, kill=0):
  - Latch divisor D = dataB.
  - Load Q = dataA and R = 0, with R WIDTH+1 bits wide.
  - Load counter = WIDTH.
  - Go to CALC. If dataB == 0, go to DONE instead.
- CALC iteration, one per cycle:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = S − {1'b0, D}, computed at WIDTH+1 bits.
  - If T[WIDTH] == 0: R = T and Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = S and Q = {Q[WIDTH-2:0], 0}.
  - Decrement the counter. The counter == 1 iteration is the last; next state is DONE.
- DONE:
  - done = 1; quot = Q and rem = R[WIDTH-1:0].
  - Next state is IDLE, or CALC/DONE if a new start is accepted in the same cycle.
- Divide by zero: quot = all ones, rem = dividend, div_zero = 1. CALC is skipped.
- div_zero clears on the next accepted start.
- Start outside IDLE/DONE is ignored; no queuing.
- Any cycle with kill = 1:
  - Next state is IDLE and done stays 0.
  - quot, rem and div_zero keep their previous values.
  - kill wins over a simultaneous start.
- rst = 1 in any state:
  - Next state is IDLE.
  - Q, R, D, counter, quot, rem, div_zero, done and busy all clear to 0.
  - rst dominates both kill and start.

## Timing
- Start accepted at edge 0, nonzero divisor:
  - busy is high from cycle 1 through cycle WIDTH.
  - done is high in cycle WIDTH+1, which is cycle 33 at default WIDTH.
  - Latency is WIDTH+1 cycles.
- Divisor 0: busy is high in cycle 1 and done is high in cycle 1.
- quot, rem and div_zero are registered and valid from the done cycle until the next accepted start.
- Back-to-back: a start during the done cycle is accepted, and busy rises in the next cycle.
- busy and done are never high together, except in the divide-by-zero done cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package pipe_cpu_pkg holds:
  - The state enum (IDLE, CALC, DONE).
  - FUNCT_DIVU = 6'd27, used by the decoder.
  - DIV_ZERO_QUOT = all ones.
- Sub-module div_step: combinational single iteration.
  - Inputs: R, Q and D.
  - Outputs: next R and next Q.
  - Uses the same subtract formulation as the ALU's Binvert path.
- Top level holds the FSM, counter and output registers.

## Test plan
- dataA=100, dataB=7: done in cycle 33 with quot=14, rem=2, div_zero=0.
- dataA=0xFFFFFFFF, dataB=1: quot=0xFFFFFFFF, rem=0. Also dataA=5, dataB=9: quot=0, rem=5.
- dataA=5, dataB=0: done in cycle 1 with quot=0xFFFFFFFF, rem=5, div_zero=1. The next valid divide clears div_zero.
- start with 50/3, then start with 9/2 at cycle 5: the second start is ignored and done in cycle 33 gives quot=16, rem=2.
- kill at cycle 10: no done, state returns to IDLE. A start at cycle 12 with 81/9 gives done in cycle 45 with quot=9, rem=0.
- rst at cycle 20 mid-divide: every output is 0 the next cycle. A start in the done cycle of 100/7 with 64/8 gives done 33 cycles later with quot=8, rem=0.
